instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Downstream of the opcode decoder; the timing backbone of the 6502-style core.
- Latches the fetched opcode into the instruction register (`ir`), which drives the decoder combinationally.
- Consumes the decoder's `cmd`/`address` outputs and steps a T-state counter through the exact cycle count of each instruction, including dynamic extensions for page crossing and taken branches.
- Tells the timing/flag-generation logic which cycle of which instruction is executing.

Parameters:
- RESET_IR, 8'h00, opcode loaded into `ir` on reset (BRK, so reset vectoring reuses the BRK sequence).
- MAX_T, 7, maximum instruction length in cycles; sizes `t_state`.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- ready  in  1  memory ready; low freezes all state (RDY stall).
- data_in  in  8  data bus; opcode captured from it during T0.
- cmd  in  6  decoded command from decoder (shared-package encoding).
- address  in  4  decoded addressing mode from decoder (shared-package encoding).
- page_cross  in  1  carry out of low-address add, from ALU.
- branch_taken  in  1  branch condition result, valid in T1 of a `rel` instruction.
- ir  out  8  instruction register, feeds decoder `opcode`.
- t_state  out  3  current cycle index, 0 = opcode fetch.
- sync  out  1  high while `t_state == 0` (opcode fetch cycle).
- instr_done  out  1  high in the final cycle of an instruction.

Behaviour:
- Reset: async on `rst`, effective immediately.
  - `ir = RESET_IR`, `t_state = 0`, `sync = 1`, `instr_done = 0`.
  - Reset mid-instruction abandons the instruction; no partial completion.
- Stall: `ready == 0` holds `ir`, `t_state` and the internal last-cycle register. Outputs stay stable; `instr_done` keeps its combinational value.
- Opcode capture: on a rising edge with `t_state == 0` and `ready`:
  - `ir <= data_in`, `t_state <= 1`.
  - `cmd`/`address` become valid from T1, one cycle latency after fetch.
- Base length N is computed combinationally in T1 from `cmd`/`address`, then registered as `last = N-1`. RMW = ASL/ROL/LSR/ROR/INC/DEC with `address != A`; store = STA/STX/STY.
  - impl/A/IMMEDIATE: N = 2, except: PHA/PHP 3, PLA/PLP 4, JSR/RTI/RTS 6, BRK 7.
  - zpg: 3 (RMW 5).
  - zpgX/zpgY: 4 (RMW 6).
  - abs: 4, except JMP 3 and RMW 6.
  - ind: 5.
  - Xind: 6.
  - absX/absY: 4, but 5 if store, 7 if RMW.
  - indY: 5, but 6 if store.
  - rel: 2.
- Dynamic extension, evaluated in the cycle where `t_state == last`:
  - absX/absY read: if `page_cross`, `last += 1`.
  - indY read: if `page_cross`, `last += 1`.
  - rel, at T1: if `branch_taken`, `last = 2`.
  - rel, at T2: if `page_cross`, `last = 3`.
  - Extensions never apply to stores or RMW, which already include the fixed cycle.
- `instr_done = (t_state == last) && t_state != 0`.
  - Next edge with `ready` sets `t_state <= 0`, unless an extension fires in that cycle, in which case `t_state <= t_state + 1`.
  - Otherwise `t_state` increments.
- Wrap-around guard: if `t_state` reaches MAX_T-1 without terminating, force return to 0. An assertion fires in simulation.
- No overlap of fetch with the last execute cycle; every instruction spends exactly one T0.

Decomposition:
- Shared package (extend the existing core package):
  - cmd constants (already defined there).
  - Addressing-mode constants: impl=0, IMMEDIATE=1, A=2, zpg=3, zpgX=4, zpgY=5, abs=6, absX=7, absY=8, ind=9, Xind=10, indY=11, rel=12.
  - `t_state` typedef.
- One sub-module: `cycle_len_lut`, purely combinational, mapping `cmd`, `address` → base N. It is reused by the coverage model.

Test Plan:
- Reset, then fetch 8'hA9 (LDA #imm) → `ir = A9`; `t_state` sequence 0,1,0; `instr_done` high in T1; `sync` high in T0 only.
- Fetch 8'hBD (LDA abs,X) with `page_cross = 0` → 4 cycles (T0–T3). Repeat with `page_cross = 1` in T3 → 5 cycles. 8'h9D (STA abs,X) → 5 cycles regardless of `page_cross`.
- Fetch 8'hD0 (BNE): `branch_taken = 0` → 2 cycles; taken, no cross → 3 cycles; taken with cross → 4 cycles.
- Fetch 8'hFE (INC abs,X) → 7 cycles. Fetch 8'h00 (BRK) → 7 cycles. Fetch 8'h20 (JSR) → 6 cycles.
- Hold `ready = 0` for 3 cycles at T2 of 8'hAD (LDA abs) → `t_state` frozen at 2, total elapsed 4+3 = 7 edges, `ir` unchanged.
- Assert `rst` asynchronously at T4 of 8'h1E (ASL abs,X) → outputs immediately `t_state = 0`, `ir = 00`, `sync = 1`. After release, BRK sequence runs 7 cycles.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// Shared core definitions: decoder command encoding, addressing modes and
// the T-state type, plus small classification helpers.
package instr_sequencer_pkg;

    localparam int MAX_T_DEF = 7;
    localparam int T_W       = 3;

    typedef logic [T_W-1:0] tstate_t;

    typedef enum logic [5:0] {
        CMD_NOP, CMD_LDA, CMD_LDX, CMD_LDY, CMD_STA, CMD_STX, CMD_STY,
        CMD_ADC, CMD_SBC, CMD_AND, CMD_ORA, CMD_EOR, CMD_CMP, CMD_CPX,
        CMD_CPY, CMD_BIT, CMD_ASL, CMD_LSR, CMD_ROL, CMD_ROR, CMD_INC,
        CMD_DEC, CMD_INX, CMD_INY, CMD_DEX, CMD_DEY, CMD_TAX, CMD_TAY,
        CMD_TXA, CMD_TYA, CMD_TSX, CMD_TXS, CMD_CLC, CMD_SEC, CMD_CLI,
        CMD_SEI, CMD_CLV, CMD_CLD, CMD_SED, CMD_JMP, CMD_JSR, CMD_RTS,
        CMD_RTI, CMD_BRK, CMD_PHA, CMD_PHP, CMD_PLA, CMD_PLP, CMD_BCC,
        CMD_BCS, CMD_BEQ, CMD_BNE, CMD_BMI, CMD_BPL, CMD_BVC, CMD_BVS
    } cmd_e;

    typedef enum logic [3:0] {
        AM_IMPL = 4'd0,  AM_IMM  = 4'd1,  AM_A    = 4'd2,  AM_ZPG  = 4'd3,
        AM_ZPGX = 4'd4,  AM_ZPGY = 4'd5,  AM_ABS  = 4'd6,  AM_ABSX = 4'd7,
        AM_ABSY = 4'd8,  AM_IND  = 4'd9,  AM_XIND = 4'd10, AM_INDY = 4'd11,
        AM_REL  = 4'd12
    } addr_e;

    // Read-modify-write only when operating on memory, not the accumulator.
    function automatic logic is_rmw(input logic [5:0] cmd, input logic [3:0] address);
        logic shift_op;
        shift_op = (cmd == CMD_ASL) || (cmd == CMD_ROL) || (cmd == CMD_LSR) ||
                   (cmd == CMD_ROR) || (cmd == CMD_INC) || (cmd == CMD_DEC);
        return shift_op && (address != AM_A);
    endfunction

    function automatic logic is_store(input logic [5:0] cmd);
        return (cmd == CMD_STA) || (cmd == CMD_STX) || (cmd == CMD_STY);
    endfunction

endpackage

// File: rtl/instr_sequencer_chk.sv
// Simulation checks for the sequencer: flags a T-state counter that runs
// into the wrap-around guard instead of terminating normally.
module instr_sequencer_chk (
    input logic clk,
    input logic rst,
    input logic ready,
    input logic guard
);

    // A correctly sized instruction never reaches the guard.
    a_no_wrap: assert property (@(posedge clk) disable iff (rst) !(ready && guard))
        else $error("instr_sequencer: t_state wrap guard forced return to T0");

endmodule

// File: rtl/instr_sequencer_cycle_len_lut.sv
// Base instruction length (in cycles) from decoded command and addressing
// mode, before any page-cross or branch-taken extension.
module cycle_len_lut
    import instr_sequencer_pkg::*;
(
    input  logic [5:0] cmd,
    input  logic [3:0] address,
    output logic [2:0] base_n
);

    logic rmw_s;
    logic store_s;

    // Length lookup keyed on addressing mode, refined by command class.
    always_comb begin
        rmw_s   = is_rmw(cmd, address);
        store_s = is_store(cmd);
        base_n  = 3'd2;
        case (address)
            AM_IMPL, AM_IMM, AM_A: begin
                case (cmd)
                    CMD_PHA, CMD_PHP:          base_n = 3'd3;
                    CMD_PLA, CMD_PLP:          base_n = 3'd4;
                    CMD_JSR, CMD_RTI, CMD_RTS: base_n = 3'd6;
                    CMD_BRK:                   base_n = 3'd7;
                    default:                   base_n = 3'd2;
                endcase
            end
            AM_ZPG:           base_n = rmw_s ? 3'd5 : 3'd3;
            AM_ZPGX, AM_ZPGY: base_n = rmw_s ? 3'd6 : 3'd4;
            AM_ABS: begin
                if (cmd == CMD_JMP) begin
                    base_n = 3'd3;
                end else if (cmd == CMD_JSR || rmw_s) begin
                    base_n = 3'd6;
                end else begin
                    base_n = 3'd4;
                end
            end
            AM_IND:           base_n = 3'd5;
            AM_XIND:          base_n = 3'd6;
            AM_ABSX, AM_ABSY: base_n = rmw_s ? 3'd7 : (store_s ? 3'd5 : 3'd4);
            AM_INDY:          base_n = store_s ? 3'd6 : 3'd5;
            AM_REL:           base_n = 3'd2;
            default:          base_n = 3'd2;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction register and T-state sequencer: fetches opcodes in T0 and
// counts execute cycles, stretching for page crossings and taken branches.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter logic [7:0] RESET_IR = 8'h00,
    parameter int         MAX_T    = MAX_T_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ready,
    input  logic [7:0] data_in,
    input  logic [5:0] cmd,
    input  logic [3:0] address,
    input  logic       page_cross,
    input  logic       branch_taken,
    output logic [7:0] ir,
    output logic [2:0] t_state,
    output logic       sync,
    output logic       instr_done
);

    localparam tstate_t GUARD_T = tstate_t'(MAX_T - 1);

    logic [7:0] ir_r;
    tstate_t    t_r;
    tstate_t    last_r;
    logic       ext_r;

    logic [2:0] base_n_s;
    tstate_t    last_eff_s;
    tstate_t    last_next_s;
    tstate_t    t_next_s;
    logic       at_last_s;
    logic       ext_s;
    logic       done_s;
    logic       guard_s;
    logic       indexed_read_s;
    logic       is_rel_s;

    cycle_len_lut u_lut (
        .cmd     (cmd),
        .address (address),
        .base_n  (base_n_s)
    );

    // Last-cycle tracking, extension decision and next T-state.
    always_comb begin
        // cmd/address only become valid in T1, so the base length is used live there.
        last_eff_s = (t_r == 3'd1) ? tstate_t'(base_n_s - 3'd1) : last_r;
        at_last_s  = (t_r == last_eff_s) && (t_r != 3'd0);
        is_rel_s   = (address == AM_REL);
        indexed_read_s = ((address == AM_ABSX) || (address == AM_ABSY) || (address == AM_INDY)) &&
                         !is_store(cmd) && !is_rmw(cmd, address);
        // ext_r keeps an indexed read from stretching more than once.
        ext_s = at_last_s &&
                ((indexed_read_s && page_cross && !ext_r) ||
                 (is_rel_s && (t_r == 3'd1) && branch_taken) ||
                 (is_rel_s && (t_r == 3'd2) && page_cross));
        done_s      = at_last_s && !ext_s;
        last_next_s = ext_s ? tstate_t'(last_eff_s + 3'd1) : last_eff_s;
        guard_s     = (t_r == GUARD_T) && !done_s;
        if (t_r == 3'd0) begin
            t_next_s = 3'd1;
        end else if (done_s || guard_s) begin
            t_next_s = 3'd0;
        end else begin
            t_next_s = t_r + 3'd1;
        end
    end

    // State registers; a low ready freezes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_r   <= RESET_IR;
            t_r    <= 3'd0;
            last_r <= 3'd0;
            ext_r  <= 1'b0;
        end else if (ready) begin
            if (t_r == 3'd0) begin
                ir_r <= data_in;
            end
            t_r    <= t_next_s;
            last_r <= last_next_s;
            ext_r  <= (t_next_s == 3'd0) ? 1'b0 : (ext_r | ext_s);
        end
    end

    assign ir         = ir_r;
    assign t_state    = t_r;
    assign sync       = (t_r == 3'd0);
    assign instr_done = done_s;

    instr_sequencer_chk u_chk (
        .clk   (clk),
        .rst   (rst),
        .ready (ready),
        .guard (guard_s)
    );

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: the bench plays the decoder, feeding
// cmd/address for each opcode, and checks cycle-by-cycle sequencing.
module tb_instr_sequencer;
    import instr_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic [5:0] cmd = CMD_NOP;
    logic [3:0] address = AM_IMPL;
    logic       page_cross = 1'b0;
    logic       branch_taken = 1'b0;
    logic [7:0] ir;
    logic [2:0] t_state;
    logic       sync;
    logic       instr_done;

    int pass_cnt = 0;
    int total    = 0;

    instr_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .ready        (ready),
        .data_in      (data_in),
        .cmd          (cmd),
        .address      (address),
        .page_cross   (page_cross),
        .branch_taken (branch_taken),
        .ir           (ir),
        .t_state      (t_state),
        .sync         (sync),
        .instr_done   (instr_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Runs one instruction from T0; page_cross is raised only in cycle pc_t,
    // branch_taken only in T1 when bt is set; n is the expected total cycles.
    task automatic run_instr(input string nm, input logic [7:0] op, input logic [5:0] c,
                             input logic [3:0] am, input int n, input int pc_t, input logic bt);
        data_in = op;
        #1;
        chk({nm, " T0 t_state"}, 8'(t_state), 8'd0);
        chk({nm, " T0 sync"}, 8'(sync), 8'd1);
        chk({nm, " T0 done"}, 8'(instr_done), 8'd0);
        for (int k = 1; k < n; k++) begin
            @(posedge clk);
            #1;
            cmd          = c;
            address      = am;
            page_cross   = (k == pc_t);
            branch_taken = bt && (k == 1);
            #1;
            chk($sformatf("%s T%0d t_state", nm, k), 8'(t_state), 8'(k));
            chk($sformatf("%s T%0d sync", nm, k), 8'(sync), 8'd0);
            chk($sformatf("%s T%0d done", nm, k), 8'(instr_done), (k == n - 1) ? 8'd1 : 8'd0);
            if (k == 1) chk({nm, " ir"}, ir, op);
        end
        @(posedge clk);
        #1;
        page_cross   = 1'b0;
        branch_taken = 1'b0;
        #1;
    endtask

    initial begin
        #12;
        chk("reset ir", ir, 8'h00);
        chk("reset t_state", 8'(t_state), 8'd0);
        chk("reset sync", 8'(sync), 8'd1);
        chk("reset done", 8'(instr_done), 8'd0);
        rst = 1'b0;

        run_instr("LDA imm",      8'hA9, CMD_LDA, AM_IMM,  2, 0, 1'b0);
        run_instr("LDA absX",     8'hBD, CMD_LDA, AM_ABSX, 4, 0, 1'b0);
        run_instr("LDA absX pc",  8'hBD, CMD_LDA, AM_ABSX, 5, 3, 1'b0);
        run_instr("STA absX pc",  8'h9D, CMD_STA, AM_ABSX, 5, 4, 1'b0);
        run_instr("BNE nt",       8'hD0, CMD_BNE, AM_REL,  2, 0, 1'b0);
        run_instr("BNE t",        8'hD0, CMD_BNE, AM_REL,  3, 0, 1'b1);
        run_instr("BNE t pc",     8'hD0, CMD_BNE, AM_REL,  4, 2, 1'b1);
        run_instr("INC absX",     8'hFE, CMD_INC, AM_ABSX, 7, 0, 1'b0);
        run_instr("BRK",          8'h00, CMD_BRK, AM_IMPL, 7, 0, 1'b0);
        run_instr("JSR",          8'h20, CMD_JSR, AM_IMPL, 6, 0, 1'b0);

        // RDY stall for three edges in T2 of LDA abs: 7 edges in total.
        data_in = 8'hAD;
        #1;
        chk("stall T0 t_state", 8'(t_state), 8'd0);
        @(posedge clk); #1;
        cmd = CMD_LDA; address = AM_ABS;
        #1;
        chk("stall T1 t_state", 8'(t_state), 8'd1);
        chk("stall T1 ir", ir, 8'hAD);
        @(posedge clk); #1;
        chk("stall T2 t_state", 8'(t_state), 8'd2);
        ready = 1'b0;
        data_in = 8'h55;
        for (int s = 0; s < 3; s++) begin
            @(posedge clk); #1;
            chk($sformatf("stall hold%0d t_state", s), 8'(t_state), 8'd2);
            chk($sformatf("stall hold%0d ir", s), ir, 8'hAD);
            chk($sformatf("stall hold%0d done", s), 8'(instr_done), 8'd0);
        end
        ready = 1'b1;
        @(posedge clk); #1;
        chk("stall T3 t_state", 8'(t_state), 8'd3);
        chk("stall T3 done", 8'(instr_done), 8'd1);
        @(posedge clk); #1;
        chk("stall end t_state", 8'(t_state), 8'd0);
        chk("stall end ir", ir, 8'hAD);

        // Asynchronous reset in T4 of ASL abs,X, then the BRK sequence.
        data_in = 8'h1E;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            cmd = CMD_ASL; address = AM_ABSX;
        end
        #1;
        chk("ASL T4 t_state", 8'(t_state), 8'd4);
        chk("ASL ir", ir, 8'h1E);
        rst = 1'b1;
        #1;
        chk("async rst t_state", 8'(t_state), 8'd0);
        chk("async rst ir", ir, 8'h00);
        chk("async rst sync", 8'(sync), 8'd1);
        chk("async rst done", 8'(instr_done), 8'd0);
        @(negedge clk);
        rst = 1'b0;
        run_instr("BRK after rst", 8'h00, CMD_BRK, AM_IMPL, 7, 0, 1'b0);
        chk("final t_state", 8'(t_state), 8'd0);
        chk("final sync", 8'(sync), 8'd1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
